// File: rtl/decode_stage.sv
// Registered RV32I/RV64I decode stage between IFU and EXU: one output entry
// with valid/ready handshake, flush, sticky EBREAK halt and an illegal counter.
module decode_stage #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [4:0]        rd,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [XLEN-1:0]   imm,
  output logic [3:0]        alu_op,
  output logic              alu_word,
  output logic              src_b_imm,
  output logic              src_a_pc,
  output logic              reg_wen,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [XLEN/8-1:0] wmask,
  output logic [1:0]        ld_size,
  output logic              ld_unsigned,
  output logic [2:0]        br_type,
  output logic              is_branch,
  output logic              is_jal,
  output logic              is_jalr,
  output logic              is_ebreak,
  output logic              illegal,
  output logic              halted,
  output logic [CNT_W-1:0]  illegal_cnt
);

  localparam int  MW      = XLEN / 8;
  localparam bit  IS_RV64 = (XLEN == 64);

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
    ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
    ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10
  } alu_op_e;

  typedef struct packed {
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    alu_op_e         alu_op;
    logic            alu_word;
    logic            src_b_imm;
    logic            src_a_pc;
    logic            reg_wen;
    logic            mem_ren;
    logic            mem_wen;
    logic [MW-1:0]   wmask;
    logic [1:0]      ld_size;
    logic            ld_unsigned;
    logic [2:0]      br_type;
    logic            is_branch;
    logic            is_jal;
    logic            is_jalr;
    logic            is_ebreak;
    logic            illegal;
  } dec_t;

  // funct3 selects the ALU op for OP/OP-IMM; alt picks SUB or SRA.
  function automatic alu_op_e f3_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic [6:0]      opcode, f7;
  logic [2:0]      f3;
  logic            f7_ok, f6_ok, illegal_c;
  logic [7:0]      mask8;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  dec_t            dec_in, dec_d, dec_q;
  logic [XLEN-1:0] pc_d, pc_q;
  logic            valid_d, valid_q, halted_d, halted_q, accept;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  assign opcode = in_inst[6:0];
  assign f3     = in_inst[14:12];
  assign f7     = in_inst[31:25];
  assign f7_ok  = (f7 == 7'h00) || (f7 == 7'h20);
  assign f6_ok  = (in_inst[31:26] == 6'h00) || (in_inst[31:26] == 6'h10);

  assign imm_i = XLEN'($signed(in_inst[31:20]));
  assign imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
  assign imm_b = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_inst[31:12], 12'h000}));
  assign imm_j = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));

  // NOTE: every signal assigned in always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    dec_in    = '0;
    illegal_c = 1'b0;
    mask8     = 8'h00;
    case (opcode)
      OPC_LUI: begin
        dec_in.rd = in_inst[11:7]; dec_in.imm = imm_u; dec_in.alu_op = ALU_PASSB;
        dec_in.src_b_imm = 1'b1; dec_in.reg_wen = 1'b1;
      end
      OPC_AUIPC, OPC_JAL: begin
        dec_in.rd = in_inst[11:7]; dec_in.alu_op = ALU_ADD;
        dec_in.imm = (opcode == OPC_JAL) ? imm_j : imm_u;
        dec_in.src_a_pc = 1'b1; dec_in.src_b_imm = 1'b1; dec_in.reg_wen = 1'b1;
        dec_in.is_jal = (opcode == OPC_JAL);
      end
      OPC_JALR: begin
        dec_in.rd = in_inst[11:7]; dec_in.rs1 = in_inst[19:15]; dec_in.imm = imm_i;
        dec_in.alu_op = ALU_ADD; dec_in.src_b_imm = 1'b1; dec_in.reg_wen = 1'b1;
        dec_in.is_jalr = 1'b1;
        illegal_c = (f3 != 3'd0);
      end
      OPC_BRANCH: begin
        dec_in.rs1 = in_inst[19:15]; dec_in.rs2 = in_inst[24:20]; dec_in.imm = imm_b;
        dec_in.alu_op = ALU_SUB; dec_in.br_type = f3; dec_in.is_branch = 1'b1;
        illegal_c = (f3 == 3'd2) || (f3 == 3'd3);
      end
      OPC_LOAD: begin
        dec_in.rd = in_inst[11:7]; dec_in.rs1 = in_inst[19:15]; dec_in.imm = imm_i;
        dec_in.alu_op = ALU_ADD; dec_in.src_b_imm = 1'b1;
        dec_in.mem_ren = 1'b1; dec_in.reg_wen = 1'b1;
        dec_in.ld_size = f3[1:0]; dec_in.ld_unsigned = f3[2];
        illegal_c = (f3 == 3'd7) || (!IS_RV64 && (f3 == 3'd3 || f3 == 3'd6));
      end
      OPC_STORE: begin
        dec_in.rs1 = in_inst[19:15]; dec_in.rs2 = in_inst[24:20]; dec_in.imm = imm_s;
        dec_in.alu_op = ALU_ADD; dec_in.src_b_imm = 1'b1; dec_in.mem_wen = 1'b1;
        case (f3)
          3'd0:    mask8 = 8'h01;
          3'd1:    mask8 = 8'h03;
          3'd2:    mask8 = 8'h0F;
          3'd3:    begin mask8 = 8'hFF; illegal_c = !IS_RV64; end
          default: illegal_c = 1'b1;
        endcase
        dec_in.wmask = mask8[MW-1:0];
      end
      OPC_OP_IMM, OPC_OP_IMM32: begin
        dec_in.rd = in_inst[11:7]; dec_in.rs1 = in_inst[19:15]; dec_in.imm = imm_i;
        dec_in.alu_op = f3_alu(f3, (f3 == 3'd5) && in_inst[30]);
        dec_in.src_b_imm = 1'b1; dec_in.reg_wen = 1'b1;
        dec_in.alu_word = (opcode == OPC_OP_IMM32);
        if (opcode == OPC_OP_IMM32)
          illegal_c = !IS_RV64 || !((f3 == 3'd0) || (f3 == 3'd1 && f7 == 7'h00) ||
                                    (f3 == 3'd5 && f7_ok));
        else if (f3 == 3'd1)
          illegal_c = IS_RV64 ? (in_inst[31:26] != 6'h00) : (f7 != 7'h00);
        else if (f3 == 3'd5)
          illegal_c = IS_RV64 ? !f6_ok : !f7_ok;
      end
      OPC_OP, OPC_OP32: begin
        dec_in.rd = in_inst[11:7]; dec_in.rs1 = in_inst[19:15]; dec_in.rs2 = in_inst[24:20];
        dec_in.alu_op = f3_alu(f3, in_inst[30]); dec_in.reg_wen = 1'b1;
        dec_in.alu_word = (opcode == OPC_OP32);
        if (opcode == OPC_OP32)
          illegal_c = !IS_RV64 || !(((f3 == 3'd0 || f3 == 3'd5) && f7_ok) ||
                                    (f3 == 3'd1 && f7 == 7'h00));
        else
          illegal_c = !((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
      end
      OPC_SYSTEM: begin
        if (in_inst == INST_EBREAK) dec_in.is_ebreak = 1'b1;
        else                        illegal_c = 1'b1;
      end
      default: illegal_c = 1'b1;
    endcase
    if (illegal_c) begin
      dec_in         = '0;
      dec_in.illegal = 1'b1;
    end
  end

  assign in_ready = !halted_q && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    dec_d    = accept ? dec_in : dec_q;
    pc_d     = accept ? in_pc  : pc_q;
    halted_d = halted_q || (accept && dec_in.is_ebreak);
    cnt_d    = cnt_q;
    if (accept && dec_in.illegal && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    valid_d  = valid_q;
    if (flush)          valid_d = 1'b0;
    else if (accept)    valid_d = 1'b1;
    else if (out_ready) valid_d = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_q    <= '0;
      pc_q     <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      dec_q    <= dec_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_pc      = pc_q;
  assign rd          = dec_q.rd;
  assign rs1         = dec_q.rs1;
  assign rs2         = dec_q.rs2;
  assign imm         = dec_q.imm;
  assign alu_op      = dec_q.alu_op;
  assign alu_word    = dec_q.alu_word;
  assign src_b_imm   = dec_q.src_b_imm;
  assign src_a_pc    = dec_q.src_a_pc;
  assign reg_wen     = dec_q.reg_wen;
  assign mem_ren     = dec_q.mem_ren;
  assign mem_wen     = dec_q.mem_wen;
  assign wmask       = dec_q.wmask;
  assign ld_size     = dec_q.ld_size;
  assign ld_unsigned = dec_q.ld_unsigned;
  assign br_type     = dec_q.br_type;
  assign is_branch   = dec_q.is_branch;
  assign is_jal      = dec_q.is_jal;
  assign is_jalr     = dec_q.is_jalr;
  assign is_ebreak   = dec_q.is_ebreak;
  assign illegal     = dec_q.illegal;
  assign halted      = halted_q;
  assign illegal_cnt = cnt_q;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RV32I/RV64I instruction-decode pipeline stage.
- Generalises the single-cycle combinational decoder in three ways:
  - Full base-integer coverage: OP, OP-IMM, W-forms, LUI, AUIPC, JAL, JALR, BRANCH, all load/store widths, EBREAK.
  - Parametrised XLEN.
  - One output register with a valid/ready handshake, flush, a sticky halt and an illegal-instruction counter.
- Sits between IFU and EXU.

Parameters:
- XLEN, 64, datapath width; only 32 or 64 are legal. With 32, LD/LWU/SD and all W-ops decode as illegal.
- CNT_W, 16, width of the saturating illegal-instruction counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  IFU offers an instruction.
- in_ready  out  1  stage can accept.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  its PC.
- flush  in  1  kill the held entry and any offered entry.
- out_valid  out  1  decoded entry valid.
- out_ready  in  1  EXU accepts.
- out_pc  out  XLEN  registered PC.
- rd, rs1, rs2  out  5 each  register indices; forced to 0 when the format has no such field.
- imm  out  XLEN  sign-extended I/S/B/U/J immediate; 0 for R-type.
- alu_op  out  4  operation code: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB.
- alu_word  out  1  32-bit op with sign-extended result (W-forms).
- src_b_imm  out  1  ALU operand B is imm rather than rs2.
- src_a_pc  out  1  ALU operand A is the PC (AUIPC, JAL).
- reg_wen  out  1  register write enable.
- mem_ren  out  1  memory read enable.
- mem_wen  out  1  memory write enable.
- wmask  out  XLEN/8  byte write mask.
- ld_size  out  2  0 byte, 1 half, 2 word, 3 dword.
- ld_unsigned  out  1  zero-extend the load.
- br_type  out  3  branch funct3 (BEQ..BGEU); is_branch qualifies it.
- is_branch, is_jal, is_jalr, is_ebreak, illegal  out  1 each  instruction-class flags.
- halted  out  1  sticky; EBREAK has been accepted.
- illegal_cnt  out  CNT_W  count of illegal instructions accepted.

Behaviour:
- Reset:
  - All outputs 0; out_valid=0, halted=0, illegal_cnt=0.
  - Reset overrides every other input in the same cycle.
- Handshake and latency:
  - in_ready = !halted & (!out_valid | out_ready).
  - Accept when in_valid & in_ready & !flush. On accept, the decoded fields and in_pc are registered and out_valid=1 the next cycle (latency 1).
  - Held entry with out_ready=0: every output stays bit-stable.
  - out_valid & out_ready with no accept: out_valid->0. With a simultaneous accept, the new entry replaces the old one back-to-back (full throughput).
- flush:
  - out_valid->0 next cycle and the offered input is dropped.
  - halted and illegal_cnt are unaffected.
- Decode rules:
  - JALR, loads and OP-IMM use ADD with an I-immediate. Stores use ADD with an S-immediate.
  - SUB/SRA are selected by funct7[5] (inst[30]). For OP-IMM shifts, RV64 uses shamt[5:0] and funct6; on RV32, inst[25]=1 is illegal.
  - LUI: PASSB with a U-immediate. AUIPC/JAL set src_a_pc. JAL/JALR set reg_wen.
  - Branches: alu_op=SUB, src_b_imm=0, imm = B-immediate.
- Store masks: SB 0x01, SH 0x03, SW 0x0F, SD 0xFF (XLEN=32 mask width is 4).
- Inst 0x00000000 is treated as illegal.
- Illegal instruction (unknown opcode/funct, or an RV64-only op with XLEN=32):
  - illegal=1; reg_wen=mem_wen=mem_ren=0.
  - On accept, illegal_cnt increments and saturates at all-ones.
- EBREAK (0x00100073):
  - is_ebreak=1.
  - On accept, halted->1 from the next cycle, so in_ready is 0 thereafter until rst.
  - The EBREAK entry itself still drains normally.
- Simultaneous flush and EBREAK offer: not accepted, so halted does not set.

Test Plan:
- addi x1,x0,5 (0x00500093), out_ready=1 -> next cycle:
  - out_valid=1, rd=1, rs1=0, imm=5.
  - alu_op=0, src_b_imm=1, reg_wen=1.
- sd x2,8(x1) (0x0020B423), XLEN=64 -> rs1=1, rs2=2, imm=8, mem_wen=1, wmask=0xFF, reg_wen=0.
- Back-to-back offers with out_ready=0 for 2 cycles:
  - in_ready=0 and outputs frozen on entry 1.
  - out_ready=1 -> entry 1 retires and entry 2 is accepted in the same cycle.
- flush=1 while out_valid=1 and in_valid=1 -> out_valid=0 next cycle; the offered entry never appears.
- ebreak 0x00100073 accepted -> out_valid=1, is_ebreak=1, halted=1, in_ready=0 persistently; rst clears halted.
- Illegal cases:
  - 0xFFFFFFFF -> illegal=1, all enables 0, illegal_cnt 0->1.
  - XLEN=32, ld x1,0(x1) (0x0000B083) -> illegal=1.
  - Counter at all-ones stays saturated.
